addsub_serial: RTL and testbench

- Parametrised sequential adder/subtractor; successor of the team's fixed 4-bit ripple adder.
- Operands are latched on a start pulse. The block then processes DIGIT bits per clock, LSB first, through a DIGIT-bit ripple slice with a registered carry.
- Provides subtract mode, carry/borrow and signed-overflow flags, and a start/busy/done handshake.
- Sits between operand registers and the display/result logic of the lab datapath.

---
 rtl/addsub_pkg.sv | 18 +
 rtl/digit_adder.sv | 26 ++
 rtl/addsub_serial.sv | 105 ++++++++++
 tb/tb_addsub_serial.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the serial adder/subtractor: FSM state encoding and counter sizing.
package addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// DIGIT-bit combinational ripple slice built from chained 1-bit full-adder cells.
module digit_adder #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  input  logic             i_ci,
  output logic [DIGIT-1:0] o_s,
  output logic             o_co,
  output logic             o_c_top
);

  logic [DIGIT:0] w_c;

  assign w_c[0] = i_ci;

  for (genvar g = 0; g < int'(DIGIT); g++) begin : g_fa
    assign o_s[g]   = i_a[g] ^ i_b[g] ^ w_c[g];
    assign w_c[g+1] = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
  end

  // Carry into the top bit lets the caller form signed overflow on the last digit.
  assign o_co    = w_c[DIGIT];
  assign o_c_top = w_c[DIGIT-1];

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial adder/subtractor: latches operands on start, processes DIGIT bits per clock
// LSB first, and commits sum, carry and signed overflow with a one-cycle done pulse.
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             in_start,
  input  logic             in_sub,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_busy,
  output logic             out_done,
  output logic [WIDTH-1:0] out_s,
  output logic             out_co,
  output logic             out_ovf
);

  localparam int unsigned N     = WIDTH / DIGIT;
  localparam int unsigned CNT_W = clog2(N);

  state_t             r_state;
  logic [WIDTH-1:0]   r_op_a;
  logic [WIDTH-1:0]   r_op_b;
  logic [WIDTH-1:0]   r_work;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;

  logic [DIGIT-1:0]   w_sum;
  logic               w_co;
  logic               w_c_top;
  logic [WIDTH-1:0]   w_work_nxt;
  logic               w_last;

  digit_adder #(
    .DIGIT (DIGIT)
  ) u_digit_adder (
    .i_a     (r_op_a[DIGIT-1:0]),
    .i_b     (r_op_b[DIGIT-1:0]),
    .i_ci    (r_carry),
    .o_s     (w_sum),
    .o_co    (w_co),
    .o_c_top (w_c_top)
  );

  // New digit enters at the top so the LSB digit lands at bit 0 after N shifts.
  assign w_work_nxt = WIDTH'({w_sum, r_work} >> DIGIT);
  assign w_last     = (r_cnt == CNT_W'(N - 1));

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      r_state  <= ST_IDLE;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_work   <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      out_busy <= 1'b0;
      out_done <= 1'b0;
      out_s    <= '0;
      out_co   <= 1'b0;
      out_ovf  <= 1'b0;
    end else begin
      out_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (in_start) begin
            r_op_a   <= in_a;
            r_op_b   <= in_sub ? ~in_b : in_b;
            r_carry  <= in_sub;
            r_work   <= '0;
            r_cnt    <= '0;
            r_state  <= ST_RUN;
            out_busy <= 1'b1;
          end else begin
            r_state  <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_op_a  <= r_op_a >> DIGIT;
          r_op_b  <= r_op_b >> DIGIT;
          r_carry <= w_co;
          r_work  <= w_work_nxt;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            out_s    <= w_work_nxt;
            out_co   <= w_co;
            out_ovf  <= w_c_top ^ w_co;
            out_busy <= 1'b0;
            out_done <= 1'b1;
            r_state  <= ST_DONE;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          out_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// Scoreboard bench: two instances (DIGIT=1 and DIGIT=4, WIDTH=8) driven with directed vectors.
module tb_addsub_serial;

  logic       clk;
  logic       rst_n;

  logic       st0, sub0, busy0, done0, co0, ovf0;
  logic [7:0] a0, b0, s0;
  logic       st1, sub1, busy1, done1, co1, ovf1;
  logic [7:0] a1, b1, s1;

  int checks;
  int fails;

  logic [9:0] q0[$];
  logic [9:0] q1[$];

  addsub_serial #(.WIDTH(8), .DIGIT(1)) u_dut0 (
    .in_clk(clk), .in_rst_n(rst_n), .in_start(st0), .in_sub(sub0),
    .in_a(a0), .in_b(b0), .out_busy(busy0), .out_done(done0),
    .out_s(s0), .out_co(co0), .out_ovf(ovf0)
  );

  addsub_serial #(.WIDTH(8), .DIGIT(4)) u_dut1 (
    .in_clk(clk), .in_rst_n(rst_n), .in_start(st1), .in_sub(sub1),
    .in_a(a1), .in_b(b1), .out_busy(busy1), .out_done(done1),
    .out_s(s1), .out_co(co1), .out_ovf(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result monitors: pop the oldest expectation whenever a done pulse is seen.
  always @(negedge clk) begin
    if (done0 === 1'b1) begin
      if (q0.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL dut0_unexpected_done actual=1 required=0 at %0t", $time);
      end else begin
        chk("dut0_result{s,co,ovf}", 32'({s0, co0, ovf0}), 32'(q0.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (done1 === 1'b1) begin
      if (q1.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL dut1_unexpected_done actual=1 required=0 at %0t", $time);
      end else begin
        chk("dut1_result{s,co,ovf}", 32'({s1, co1, ovf1}), 32'(q1.pop_front()));
      end
    end
  end

  task automatic drive(input int sel, input logic st, input logic [7:0] a, input logic [7:0] b,
                       input logic sub);
    if (sel == 0) begin
      st0 = st; a0 = a; b0 = b; sub0 = sub;
    end else begin
      st1 = st; a1 = a; b1 = b; sub1 = sub;
    end
  endtask

  // One isolated operation with busy/done timing checks; operands scrambled after latching.
  task automatic run_op(input int sel, input logic [7:0] a, input logic [7:0] b, input logic sub,
                        input logic [7:0] es, input logic eco, input logic eovf);
    int n;
    logic bz, dn;
    n = (sel == 0) ? 8 : 2;
    if (sel == 0) q0.push_back({es, eco, eovf});
    else          q1.push_back({es, eco, eovf});
    @(negedge clk);
    drive(sel, 1'b1, a, b, sub);
    for (int j = 1; j <= n + 2; j++) begin
      @(negedge clk);
      if (j == 1) drive(sel, 1'b0, ~a, ~b, ~sub);
      bz = (sel == 0) ? busy0 : busy1;
      dn = (sel == 0) ? done0 : done1;
      chk($sformatf("dut%0d_busy_c%0d", sel, j), 32'(bz), 32'(j <= n));
      chk($sformatf("dut%0d_done_c%0d", sel, j), 32'(dn), 32'(j == n + 1));
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst_n  = 1'b0;
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_s0", 32'(s0), 32'h0);
    chk("rst_co0", 32'(co0), 32'h0);
    chk("rst_ovf0", 32'(ovf0), 32'h0);
    chk("rst_busy0", 32'(busy0), 32'h0);
    chk("rst_done0", 32'(done0), 32'h0);
    chk("rst_s1", 32'(s1), 32'h0);
    chk("rst_busy1", 32'(busy1), 32'h0);
    chk("rst_done1", 32'(done1), 32'h0);
    rst_n = 1'b1;

    // DIGIT=1 vectors
    run_op(0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    run_op(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op(0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op(0, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op(0, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

    // DIGIT=4 vectors
    run_op(1, 8'h3C, 8'h4B, 1'b0, 8'h87, 1'b0, 1'b1);
    run_op(1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op(1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    run_op(1, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);

    // Back-to-back with start held high; inputs changed mid-RUN must not disturb in-flight work.
    q0.push_back({8'h10, 1'b0, 1'b0});
    q0.push_back({8'hFE, 1'b0, 1'b0});
    q0.push_back({8'h7F, 1'b1, 1'b1});
    @(negedge clk);
    drive(0, 1'b1, 8'h0F, 8'h01, 1'b0);
    for (int j = 1; j <= 28; j++) begin
      @(negedge clk);
      if (j == 4)  drive(0, 1'b1, 8'h05, 8'h07, 1'b1);
      if (j == 13) drive(0, 1'b1, 8'h80, 8'h01, 1'b1);
      if (j == 22) drive(0, 1'b0, 8'h80, 8'h01, 1'b1);
      chk($sformatf("b2b_done_c%0d", j), 32'(done0), 32'((j % 9) == 0 && j <= 27));
      chk($sformatf("b2b_busy_c%0d", j), 32'(busy0), 32'((j % 9) != 0 && j <= 26));
    end

    // Reset in the middle of a run: everything clears, no done pulse follows.
    @(negedge clk);
    drive(0, 1'b1, 8'h12, 8'h34, 1'b0);
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      if (j == 1) drive(0, 1'b0, 8'h12, 8'h34, 1'b0);
    end
    chk("pre_rst_busy0", 32'(busy0), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_s0", 32'(s0), 32'h0);
    chk("mid_rst_co0", 32'(co0), 32'h0);
    chk("mid_rst_ovf0", 32'(ovf0), 32'h0);
    chk("mid_rst_busy0", 32'(busy0), 32'h0);
    chk("mid_rst_done0", 32'(done0), 32'h0);
    chk("mid_rst_s1", 32'(s1), 32'h0);
    rst_n = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      chk($sformatf("post_rst_idle_busy_c%0d", j), 32'(busy0), 32'h0);
    end

    // Normal operation resumes after reset.
    run_op(0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    chk("dut0_pending_expectations", 32'(q0.size()), 32'h0);
    chk("dut1_pending_expectations", 32'(q1.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
